// File: rtl/m0_control_unit.sv
// m0_control_unit: multi-cycle sequencing FSM (vector load, then FETCH..WRITEBACK per instruction)
// Ports: clk; rst (async, active-high); update_flags/write_rd decode hints, sampled leaving EXECUTE;
//   strobes cu_wr_mem, new_pc_en, cu_decode, cu_execute;
//   loads ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ild_primask.
module m0_control_unit #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic update_flags,
  input  logic write_rd,
  output logic cu_wr_mem,
  output logic new_pc_en,
  output logic cu_decode,
  output logic cu_execute,
  output logic ld_sp,
  output logic ld_lr,
  output logic ld_pc,
  output logic ld_rd,
  output logic ld_apsr,
  output logic ld_ipsr,
  output logic ild_primask
);
  localparam logic [2:0] RESET     = 3'd0;
  localparam logic [2:0] INIT_SP   = 3'd1;
  localparam logic [2:0] INIT_PC   = 3'd2;
  localparam logic [2:0] FETCH     = 3'd3;
  localparam logic [2:0] DECODE    = 3'd4;
  localparam logic [2:0] EXECUTE   = 3'd5;
  localparam logic [2:0] MEMORY    = 3'd6;
  localparam logic [2:0] WRITEBACK = 3'd7;
  localparam logic [3:0] MW = 4'(MEM_WAIT);
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wb_rd_q, wb_rd_d, wb_flags_q, wb_flags_d;
  always_comb begin
    state_d = INIT_SP;
    cnt_d = 4'd0;
    wb_rd_d = wb_rd_q;
    wb_flags_d = wb_flags_q;
    case (state_q)
      INIT_SP:   state_d = INIT_PC;
      INIT_PC:   state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE: begin
        state_d = MEMORY;
        wb_rd_d = write_rd;
        wb_flags_d = update_flags;
      end
      MEMORY: begin
        state_d = cnt_q == MW ? WRITEBACK : MEMORY;
        cnt_d = cnt_q == MW ? 4'd0 : cnt_q + 4'd1;
      end
      WRITEBACK: state_d = FETCH;
      default:   state_d = INIT_SP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET;
      cnt_q <= 4'd0;
      wb_rd_q <= 1'b0;
      wb_flags_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wb_rd_q <= wb_rd_d;
      wb_flags_q <= wb_flags_d;
    end
  end
  logic init_sp;
  logic wb;
  assign init_sp = state_q == INIT_SP;
  assign wb = state_q == WRITEBACK;
  // Only the first MEMORY cycle opens the write window; wait cycles stay quiet.
  assign cu_wr_mem = state_q == MEMORY && cnt_q == 4'd0;
  assign new_pc_en = state_q == FETCH;
  assign cu_decode = state_q == DECODE;
  assign cu_execute = state_q == EXECUTE;
  assign ld_sp = init_sp;
  assign ld_lr = init_sp;
  assign ld_ipsr = init_sp;
  assign ild_primask = init_sp;
  assign ld_pc = state_q == INIT_PC;
  assign ld_rd = wb & wb_rd_q;
  assign ld_apsr = init_sp | (wb & wb_flags_q);
endmodule

// File: tb/tb_m0_control_unit.sv
module tb_m0_control_unit;
  typedef struct packed {
    logic [10:0] e;
    logic h;
    logic wr;
    logic uf;
  } rec_t;
  // output vector bit order:
  // {cu_wr_mem,new_pc_en,cu_decode,cu_execute,ld_sp,ld_lr,ld_pc,ld_rd,ld_apsr,ld_ipsr,ild_primask}
  localparam logic [10:0] V_ISP = 11'h067;
  localparam logic [10:0] V_IPC = 11'h010;
  localparam logic [10:0] V_FET = 11'h200;
  localparam logic [10:0] V_DEC = 11'h100;
  localparam logic [10:0] V_EXE = 11'h080;
  localparam logic [10:0] V_MEM = 11'h400;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr0 = 1'b0, uf0 = 1'b0, wr1 = 1'b0, uf1 = 1'b0;
  logic [10:0] o0, o1;
  logic [10:0] q0[$], q1[$];
  rec_t plan[2][16];
  int plen[2], ppos[2], ninst[2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  m0_control_unit #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .update_flags(uf0), .write_rd(wr0),
    .cu_wr_mem(o0[10]), .new_pc_en(o0[9]), .cu_decode(o0[8]), .cu_execute(o0[7]),
    .ld_sp(o0[6]), .ld_lr(o0[5]), .ld_pc(o0[4]), .ld_rd(o0[3]), .ld_apsr(o0[2]),
    .ld_ipsr(o0[1]), .ild_primask(o0[0])
  );
  m0_control_unit #(.MEM_WAIT(3)) dut1 (
    .clk(clk), .rst(rst), .update_flags(uf1), .write_rd(wr1),
    .cu_wr_mem(o1[10]), .new_pc_en(o1[9]), .cu_decode(o1[8]), .cu_execute(o1[7]),
    .ld_sp(o1[6]), .ld_lr(o1[5]), .ld_pc(o1[4]), .ld_rd(o1[3]), .ld_apsr(o1[2]),
    .ld_ipsr(o1[1]), .ild_primask(o1[0])
  );
  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t outputs=%h expected=%h", name, $time, act, exp);
    end
    total++;
    if ($countones(act[10:7]) > 1) begin
      bad++;
      $display("FAIL %s_onehot t=%0t strobes=%b expected at most one set", name, $time, act[10:7]);
    end
  endtask
  // One instruction = FETCH, DECODE, EXECUTE, 1+w MEMORY cycles, WRITEBACK.
  task automatic gen(input int k);
    int w;
    logic a, b;
    w = k == 0 ? 0 : 3;
    ninst[k]++;
    a = ninst[k] == 1 ? 1'b1 : ninst[k] <= 3 ? 1'b0 : 1'($urandom_range(0, 1));
    b = ninst[k] == 2 ? 1'b1 : ninst[k] <= 3 ? 1'b0 : 1'($urandom_range(0, 1));
    plan[k][0] = '{V_FET, 1'b0, 1'b0, 1'b0};
    plan[k][1] = '{V_DEC, 1'b0, 1'b0, 1'b0};
    plan[k][2] = '{V_EXE, 1'b1, a, b};
    plan[k][3] = '{V_MEM, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < w; i++) plan[k][4 + i] = '{11'h000, 1'b0, 1'b0, 1'b0};
    plan[k][4 + w] = '{{7'b0, a, b, 2'b0}, 1'b0, 1'b0, 1'b0};
    plen[k] = 5 + w;
    ppos[k] = 0;
  endtask
  always @(negedge clk) begin
    if (q0.size() > 0) chk("mw0", o0, q0.pop_front());
    if (q1.size() > 0) chk("mw3", o1, q1.pop_front());
  end
  initial begin
    int rcnt;
    bit released, mid_done;
    rec_t r;
    logic a, b;
    rcnt = 2;
    released = 0;
    mid_done = 0;
    ninst[0] = 0;
    ninst[1] = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(posedge clk);
      #1;
      if (!mid_done && released && ninst[0] >= 20 && ppos[0] < plen[0] && plan[0][ppos[0]].e == V_MEM) begin
        mid_done = 1;
        rcnt = 3;
      end
      if (rcnt > 0 || !released && rcnt == 0) begin
        rst = rcnt > 0;
        released = rcnt == 0;
        if (rcnt > 0) rcnt--;
        {wr0, uf0, wr1, uf1} = 4'($urandom);
        q0.push_back(11'h000);
        q1.push_back(11'h000);
        if (released)
          for (int k = 0; k < 2; k++) begin
            plan[k][0] = '{V_ISP, 1'b0, 1'b0, 1'b0};
            plan[k][1] = '{V_IPC, 1'b0, 1'b0, 1'b0};
            plen[k] = 2;
            ppos[k] = 0;
          end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (ppos[k] == plen[k]) gen(k);
          r = plan[k][ppos[k]];
          ppos[k]++;
          a = r.h ? r.wr : 1'($urandom_range(0, 1));
          b = r.h ? r.uf : 1'($urandom_range(0, 1));
          if (k == 0) begin
            wr0 = a;
            uf0 = b;
            q0.push_back(r.e);
          end else begin
            wr1 = a;
            uf1 = b;
            q1.push_back(r.e);
          end
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d expected=0", q0.size() + q1.size());
    end
    total++;
    if (!mid_done || ninst[0] < 100) begin
      bad++;
      $display("FAIL coverage mid_reset=%0d instr=%0d expected 1 and >=100", mid_done, ninst[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
